// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// This file holds the register geometry and the index of each writeback requester.
package rf_wb_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int RADDR_W  = 5;
  localparam int ZERO_REG = 0;

  localparam int WB_EX    = 0;
  localparam int WB_LSU   = WB_EX + 1;
  localparam int WB_DIV   = WB_LSU + 1;
  localparam int NUM_REQ  = WB_DIV + 1;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// The pointer moves just past the winner whenever a grant is made.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               grant_any_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W-1:0]   w_gidx;
  logic               w_found;
  logic [NUM_REQ-1:0] w_grant;

  // Cyclic search from the pointer; grants are suppressed while in reset
  always_comb begin
    w_found = 1'b0;
    w_gidx  = r_ptr;
    w_idx   = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end else begin
        w_found = w_found;
      end
    end
    w_grant = {NUM_REQ{w_found & rst_n}} & (NUM_REQ'(1) << w_gidx);
  end

  assign grant_o     = w_grant;
  assign grant_any_o = w_found & rst_n;

  // Pointer register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= PTR_W'((int'(w_gidx) + 1) % NUM_REQ);
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with a one-stage writeback register and a
// pending-destination scoreboard that stalls decode on RAW/WAW hazards.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = rf_wb_arbiter_pkg::NUM_REQ,
  parameter int XLEN    = rf_wb_arbiter_pkg::XLEN,
  parameter int RADDR_W = rf_wb_arbiter_pkg::RADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*RADDR_W-1:0] req_waddr_i,
  input  logic [NUM_REQ*XLEN-1:0]    req_wdata_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic                       issue_valid_i,
  input  logic [RADDR_W-1:0]         issue_rd_i,
  input  logic [RADDR_W-1:0]         rs1_i,
  input  logic [RADDR_W-1:0]         rs2_i,
  output logic                       id_stall_o,
  output logic                       reg_wen_o,
  output logic [RADDR_W-1:0]         reg_waddr_o,
  output logic [XLEN-1:0]            reg_wdata_o
);

  localparam int                 NUM_REGS = 1 << RADDR_W;
  localparam logic [RADDR_W-1:0] X0       = RADDR_W'(ZERO_REG);

  logic [NUM_REQ-1:0]  w_grant;
  logic                w_grant_any;
  logic [RADDR_W-1:0]  w_sel_waddr;
  logic [XLEN-1:0]     w_sel_wdata;
  logic                r_wen;
  logic [RADDR_W-1:0]  r_waddr;
  logic [XLEN-1:0]     r_wdata;
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_set_mask;
  logic                w_raw1;
  logic                w_raw2;
  logic                w_waw;
  logic                w_stall;
  logic                w_issue_set;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_valid_i),
    .grant_o     (w_grant),
    .grant_any_o (w_grant_any)
  );

  assign req_ready_o = w_grant;

  // Grant is one-hot, so an AND-OR reduction selects the winning slice
  always_comb begin
    w_sel_waddr = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_waddr = w_sel_waddr | (req_waddr_i[i*RADDR_W +: RADDR_W] & {RADDR_W{w_grant[i]}});
      w_sel_wdata = w_sel_wdata | (req_wdata_i[i*XLEN +: XLEN] & {XLEN{w_grant[i]}});
    end
  end

  // A register being written this cycle is bypassed by the register file
  function automatic logic hazard(input logic [NUM_REGS-1:0] pend,
                                  input logic [RADDR_W-1:0]  r,
                                  input logic                wen,
                                  input logic [RADDR_W-1:0]  waddr);
    return (r != X0) && pend[r] && !(wen && (waddr == r));
  endfunction

  assign w_raw1      = hazard(r_pending, rs1_i, r_wen, r_waddr);
  assign w_raw2      = hazard(r_pending, rs2_i, r_wen, r_waddr);
  assign w_waw       = issue_valid_i & hazard(r_pending, issue_rd_i, r_wen, r_waddr);
  assign w_stall     = rst_n & (w_raw1 | w_raw2 | w_waw);
  assign id_stall_o  = w_stall;
  assign w_issue_set = issue_valid_i & ~w_stall & (issue_rd_i != X0);

  // Clear then set, so a same-cycle issue of the written rd keeps it pending
  assign w_clr_mask    = NUM_REGS'(r_wen) << r_waddr;
  assign w_set_mask    = NUM_REGS'(w_issue_set) << issue_rd_i;
  assign w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;

  // Scoreboard register; x0 is never pending
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= {w_pending_nxt[NUM_REGS-1:1], 1'b0};
    end
  end

  // Writeback register: x0 writes are accepted but never enabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_grant_any) begin
      r_wen   <= (w_sel_waddr != X0);
      r_waddr <= w_sel_waddr;
      r_wdata <= w_sel_wdata;
    end else begin
      r_wen   <= 1'b0;
    end
  end

  assign reg_wen_o   = r_wen;
  assign reg_waddr_o = r_waddr;
  assign reg_wdata_o = r_wdata;

endmodule
